// File: rtl/prediction_update_buffer.sv
// Branch-predictor table write-back buffer: counter update plus DEPTH-entry FIFO.
// Optional same-entry merging of back-to-back updates: `define PRED_UPD_MERGE_EN.
module prediction_update_buffer #(
  parameter int NUM_PRED    = 3,
  parameter int ADDR_WIDTH  = 3,
  parameter int INDEX_WIDTH = 2,
  parameter int STAT_WIDTH  = 5,
  parameter int TREND_WIDTH = 3,
  parameter int DEPTH       = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            upd_valid,
  output logic                            upd_ready,
  input  logic [ADDR_WIDTH-1:0]           upd_addr,
  input  logic                            upd_taken,
  input  logic [NUM_PRED*INDEX_WIDTH-1:0] upd_index,
  input  logic [NUM_PRED*STAT_WIDTH-1:0]  upd_stat,
  input  logic [NUM_PRED*TREND_WIDTH-1:0] upd_trend,
  output logic                            wr_valid,
  input  logic                            wr_ready,
  output logic [ADDR_WIDTH-1:0]           wr_addr,
  output logic [NUM_PRED*INDEX_WIDTH-1:0] wr_index,
  output logic [NUM_PRED*STAT_WIDTH-1:0]  wr_stat,
  output logic [NUM_PRED*TREND_WIDTH-1:0] wr_trend,
  output logic [NUM_PRED-1:0]             wr_stat_en,
  output logic                            wr_clear,
  output logic [$clog2(DEPTH+1)-1:0]      count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = NUM_PRED*INDEX_WIDTH;
  localparam int SW = STAT_WIDTH;
  localparam int TW = TREND_WIDTH;

  localparam logic signed [SW-1:0] SMAX = {1'b0, {(SW-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {1'b1, {(SW-1){1'b0}}};
  localparam logic signed [TW-1:0] TMAX = {1'b0, {(TW-1){1'b1}}};
  localparam logic signed [TW-1:0] TNEG = -TMAX;

  logic [ADDR_WIDTH-1:0]  r_addr  [DEPTH];
  logic [IW-1:0]          r_index [DEPTH];
  logic [NUM_PRED*SW-1:0] r_stat  [DEPTH];
  logic [NUM_PRED*TW-1:0] r_trend [DEPTH];
  logic [NUM_PRED-1:0]    r_en    [DEPTH];
  logic [DEPTH-1:0]       r_clear;
  logic [PW-1:0]          r_wp;
  logic [PW-1:0]          r_rp;
  logic [CW-1:0]          r_count;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_merge;
  logic                   w_alloc;
  logic [PW-1:0]          w_young;
  logic [NUM_PRED*SW-1:0] w_base_stat;
  logic [NUM_PRED*TW-1:0] w_base_trend;
  logic [NUM_PRED*SW-1:0] w_new_stat;
  logic [NUM_PRED*TW-1:0] w_new_trend;
  logic [NUM_PRED-1:0]    w_new_en;
  logic                   w_new_clear;

  assign upd_ready = (r_count != CW'(DEPTH));
  assign wr_valid  = (r_count != '0);
  assign w_push    = upd_valid && upd_ready;
  assign w_pop     = wr_valid && wr_ready;
  assign w_young   = r_wp - 1'b1;

`ifdef PRED_UPD_MERGE_EN
  logic w_match;
  // The youngest slot is only mergeable if it is not leaving this cycle.
  assign w_match = wr_valid
                && (upd_addr == r_addr[w_young])
                && (upd_index == r_index[w_young])
                && !(w_pop && r_count == CW'(1));
  assign w_merge      = w_push && w_match;
  assign w_base_stat  = w_merge ? r_stat[w_young]  : upd_stat;
  assign w_base_trend = w_merge ? r_trend[w_young] : upd_trend;
`else
  assign w_merge      = 1'b0;
  assign w_base_stat  = upd_stat;
  assign w_base_trend = upd_trend;
`endif

  assign w_alloc = w_push && !w_merge;

  for (genvar g = 0; g < NUM_PRED; g++) begin : g_pred
    logic                 w_fail;
    logic                 w_ovf;
    logic signed [SW-1:0] w_s;
    logic signed [TW-1:0] w_t;
    logic signed [TW-1:0] w_tn;

    assign w_fail = upd_taken != upd_index[g*INDEX_WIDTH + INDEX_WIDTH-1];
    assign w_s    = w_base_stat[g*SW +: SW];
    assign w_t    = w_base_trend[g*TW +: TW];
    assign w_ovf  = w_fail ? (w_s == SMAX) : (w_s == SMIN);

    always_comb begin
      w_tn = w_t;
      if (w_fail) w_tn = (w_t <= TNEG) ? TNEG : w_t - 1'b1;
      else        w_tn = (w_t >= TMAX) ? TMAX : w_t + 1'b1;
    end

    assign w_new_stat[g*SW +: SW]  = w_fail ? w_s + 1'b1 : w_s - 1'b1;
    assign w_new_trend[g*TW +: TW] = w_tn;
    assign w_new_en[g]             = !w_ovf;
  end

  assign w_new_clear = ~&w_new_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i]  <= '0;
        r_index[i] <= '0;
        r_stat[i]  <= '0;
        r_trend[i] <= '0;
        r_en[i]    <= '0;
      end
      r_clear <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) r_rp <= r_rp + 1'b1;
      if (w_alloc) begin
        r_addr[r_wp]  <= upd_addr;
        r_index[r_wp] <= upd_index;
        r_stat[r_wp]  <= w_new_stat;
        r_trend[r_wp] <= w_new_trend;
        r_en[r_wp]    <= w_new_en;
        r_clear[r_wp] <= w_new_clear;
        r_wp          <= r_wp + 1'b1;
      end else if (w_merge) begin
        r_stat[w_young]  <= w_new_stat;
        r_trend[w_young] <= w_new_trend;
        r_en[w_young]    <= r_en[w_young] & w_new_en;
        r_clear[w_young] <= r_clear[w_young] | w_new_clear;
      end
      unique case ({w_alloc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign wr_addr    = r_addr[r_rp];
  assign wr_index   = r_index[r_rp];
  assign wr_stat    = r_stat[r_rp];
  assign wr_trend   = r_trend[r_rp];
  assign wr_stat_en = r_en[r_rp];
  assign wr_clear   = r_clear[r_rp];
  assign count      = r_count;

endmodule

// File: tb/tb_prediction_update_buffer.sv
// Directed bench for prediction_update_buffer at default parameters.
// Expected values are hand-computed per scenario.
module tb_prediction_update_buffer;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        upd_valid;
  logic        upd_ready;
  logic [2:0]  upd_addr;
  logic        upd_taken;
  logic [5:0]  upd_index;
  logic [14:0] upd_stat;
  logic [8:0]  upd_trend;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_addr;
  logic [5:0]  wr_index;
  logic [14:0] wr_stat;
  logic [8:0]  wr_trend;
  logic [2:0]  wr_stat_en;
  logic        wr_clear;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  prediction_update_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_addr   (upd_addr),
    .upd_taken  (upd_taken),
    .upd_index  (upd_index),
    .upd_stat   (upd_stat),
    .upd_trend  (upd_trend),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_index   (wr_index),
    .wr_stat    (wr_stat),
    .wr_trend   (wr_trend),
    .wr_stat_en (wr_stat_en),
    .wr_clear   (wr_clear),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] a, input logic t,
                       input logic [5:0] ix, input logic [14:0] s,
                       input logic [8:0] tr);
    upd_valid = 1'b1;
    upd_addr  = a;
    upd_taken = t;
    upd_index = ix;
    upd_stat  = s;
    upd_trend = tr;
  endtask

  task automatic drain();
    wr_ready = 1'b1;
    for (int k = 0; k < 10 && count != 0; k++) step();
    chk("drain_empty", 32'(count), 32'd0);
    wr_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; upd_valid = 1'b0; wr_ready = 1'b0;
    upd_addr = '0; upd_taken = 1'b0; upd_index = '0;
    upd_stat = '0; upd_trend = '0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_count",  32'(count),      32'd0);
    chk("rst_wvalid", 32'(wr_valid),   32'd0);
    chk("rst_uready", 32'(upd_ready),  32'd1);
    chk("rst_addr",   32'(wr_addr),    32'd0);
    chk("rst_stat",   32'(wr_stat),    32'd0);
    chk("rst_en",     32'(wr_stat_en), 32'd0);

    // basic update: pred0 hit, pred1 miss, pred2 hit
    wr_ready = 1'b1;
    drive(3'd5, 1'b1, {2'b10, 2'b01, 2'b11}, '0, '0);
    step();
    upd_valid = 1'b0;
    chk("b_wvalid", 32'(wr_valid),   32'd1);
    chk("b_addr",   32'(wr_addr),    32'd5);
    chk("b_stat",   32'(wr_stat),    32'({5'h1F, 5'h01, 5'h1F}));
    chk("b_trend",  32'(wr_trend),   32'({3'h1, 3'h7, 3'h1}));
    chk("b_en",     32'(wr_stat_en), 32'd7);
    chk("b_clear",  32'(wr_clear),   32'd0);
    step();
    chk("b_count0", 32'(count), 32'd0);

    // pred0 miss at stat max and trend -3; pred1 hit at trend +3
    drive(3'd2, 1'b1, {2'b10, 2'b10, 2'b00},
          {5'd0, 5'd0, 5'd15}, {3'h0, 3'h3, 3'h5});
    step();
    upd_valid = 1'b0;
    chk("o_en",    32'(wr_stat_en),    32'b110);
    chk("o_clear", 32'(wr_clear),      32'd1);
    chk("o_trend", 32'(wr_trend),      32'({3'h1, 3'h3, 3'h5}));
    chk("o_stat",  32'(wr_stat[14:5]), 32'({5'h1F, 5'h1F}));
    step();
    wr_ready = 1'b0;

    // fill to full with distinct addresses, then drain in order
    for (int a = 1; a <= 4; a++) begin
      drive(3'(a), 1'b0, 6'b0, '0, '0);
      step();
    end
    upd_valid = 1'b0;
    chk("f_count",  32'(count),     32'd4);
    chk("f_uready", 32'(upd_ready), 32'd0);
    chk("f_head",   32'(wr_addr),   32'd1);
    chk("f_stat",   32'(wr_stat),   32'({5'h1F, 5'h1F, 5'h1F}));
    drive(3'd7, 1'b0, 6'b0, '0, '0);
    step(); step();
    upd_valid = 1'b0;
    chk("f_hold_cnt",  32'(count),   32'd4);
    chk("f_hold_addr", 32'(wr_addr), 32'd1);
    wr_ready = 1'b1;
    for (int a = 2; a <= 4; a++) begin
      step();
      chk("f_order", 32'(wr_addr), 32'(a));
      chk("f_cnt",   32'(count),   32'(5 - a));
    end
    step();
    chk("f_empty", 32'(wr_valid), 32'd0);
    wr_ready = 1'b0;

    // two same-key misses on consecutive cycles
    drive(3'd6, 1'b1, 6'b0, '0, '0);
    step(); step();
    upd_valid = 1'b0;
`ifdef PRED_UPD_MERGE_EN
    chk("m_count", 32'(count),    32'd1);
    chk("m_stat",  32'(wr_stat),  32'({5'h02, 5'h02, 5'h02}));
    chk("m_trend", 32'(wr_trend), 32'({3'h6, 3'h6, 3'h6}));
`else
    chk("m_count",  32'(count),    32'd2);
    chk("m_stat0",  32'(wr_stat),  32'({5'h01, 5'h01, 5'h01}));
    chk("m_trend0", 32'(wr_trend), 32'({3'h7, 3'h7, 3'h7}));
    wr_ready = 1'b1;
    step();
    wr_ready = 1'b0;
    chk("m_stat1",  32'(wr_stat),  32'({5'h01, 5'h01, 5'h01}));
    chk("m_trend1", 32'(wr_trend), 32'({3'h7, 3'h7, 3'h7}));
`endif
    drain();

    // flush with a concurrent push
    for (int a = 1; a <= 3; a++) begin
      drive(3'(a), 1'b0, 6'b0, '0, '0);
      step();
    end
    chk("fl_pre", 32'(count), 32'd3);
    drive(3'd4, 1'b0, 6'b0, '0, '0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    upd_valid = 1'b0;
    chk("fl_count",  32'(count),    32'd0);
    chk("fl_wvalid", 32'(wr_valid), 32'd0);

    // reset mid-drain
    for (int a = 5; a <= 7; a++) begin
      drive(3'(a), 1'b1, 6'b0, '0, '0);
      step();
    end
    upd_valid = 1'b0;
    wr_ready = 1'b1;
    step();
    chk("r_pre", 32'(count), 32'd2);
    drive(3'd1, 1'b1, 6'b0, '0, '0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    upd_valid = 1'b0;
    wr_ready = 1'b0;
    chk("r_count",  32'(count),      32'd0);
    chk("r_wvalid", 32'(wr_valid),   32'd0);
    chk("r_uready", 32'(upd_ready),  32'd1);
    chk("r_addr",   32'(wr_addr),    32'd0);
    chk("r_index",  32'(wr_index),   32'd0);
    chk("r_stat",   32'(wr_stat),    32'd0);
    chk("r_trend",  32'(wr_trend),   32'd0);
    chk("r_en",     32'(wr_stat_en), 32'd0);
    chk("r_clear",  32'(wr_clear),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prediction_update_buffer.md
# prediction_update_buffer

Parametrised write-back stage for the branch predictor tables. It accepts resolved-branch update requests for `NUM_PRED` component predictors and computes each predictor's new trend and stat counter values. Results are held in a `DEPTH`-entry FIFO, where back-to-back updates to the same table entry are merged into one slot. The FIFO drains one table write per handshake. The block sits between branch resolution in EX and the predictor table write ports, and replaces fixed two-port direct writing with a buffered, backpressured path.

## Interface
Parameters:
- `NUM_PRED`, 3: number of component predictors (channels).
- `ADDR_WIDTH`, 3: predictor table address width.
- `INDEX_WIDTH`, 2: per-predictor sub-index width. Its MSB is that predictor's predicted direction.
- `STAT_WIDTH`, 5: signed stat counter width.
- `TREND_WIDTH`, 3: signed trend counter width.
- `DEPTH`, 4: FIFO entries. Must be a power of two, ≥2.

Ports:
- `clk`  in  1  clock. All logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  discard all buffered entries.
- `upd_valid`  in  1  update request valid.
- `upd_ready`  out  1  buffer can accept an update.
- `upd_addr`  in  `ADDR_WIDTH`  table address.
- `upd_taken`  in  1  resolved branch direction.
- `upd_index`  in  `NUM_PRED*INDEX_WIDTH`  per-predictor index. Predictor i occupies slice i.
- `upd_stat`  in  `NUM_PRED*STAT_WIDTH`  current stat counters as read.
- `upd_trend`  in  `NUM_PRED*TREND_WIDTH`  current trend counters as read.
- `wr_valid`  out  1  head entry available.
- `wr_ready`  in  1  table accepts the write.
- `wr_addr`  out  `ADDR_WIDTH`  head address.
- `wr_index`  out  `NUM_PRED*INDEX_WIDTH`  head indices.
- `wr_stat`  out  `NUM_PRED*STAT_WIDTH`  new stat counters.
- `wr_trend`  out  `NUM_PRED*TREND_WIDTH`  new trend counters.
- `wr_stat_en`  out  `NUM_PRED`  per-predictor stat write enable.
- `wr_clear`  out  1  clear all stat counters of `wr_addr`.
- `count`  out  `$clog2(DEPTH+1)`  occupied entries.

## Operation
- Per-predictor miss: `fail[i] = upd_taken != upd_index[i][MSB]`.
- Trend update: −1 on a miss, +1 on a hit. Saturates at ±(2^(TREND_WIDTH−1)−1), i.e. ±3 at default width. The most negative code is never produced.
- Stat update: +1 on a miss, −1 on a hit, two's-complement `STAT_WIDTH`.
  - Overflow (result leaves [−2^(S−1), 2^(S−1)−1]) clears `stat_en[i]` and sets the entry's `clear` flag.
  - Non-overflowed predictors have `stat_en[i]=1`.
- Each FIFO entry holds addr, index, new stat, new trend, stat_en and clear.
- Push happens when `upd_valid && upd_ready`. Pop happens when `wr_valid && wr_ready`.
- `upd_ready = (count < DEPTH)`. It is registered-state only, with no combinational path from `upd_*`.
- Merge (with `PRED_UPD_MERGE_EN`):
  - Trigger: the incoming addr and all index fields equal those of the youngest entry, and that entry is not being popped this cycle.
  - The update is applied to the stored values rather than the stale `upd_stat`/`upd_trend`: ±1 on stored stat and trend, same saturation and overflow rules.
  - `stat_en` is ANDed and `clear` is ORed into the stored entry.
  - `count` is unchanged.
- Simultaneous push and pop: count is unchanged, both take effect.
- `flush` beats push and pop: `count` becomes 0 at the next edge and accepted data that cycle is dropped.
- `wr_*` are driven from the head storage register, so they are glitch-free and registered.

## Timing
- Latency: an update accepted at edge N is visible on `wr_*` with `wr_valid=1` after edge N, if the FIFO was empty.
- A merged update changes the youngest entry's contents after its edge.
- Reset (`rst=1` at an edge):
  - `count=0`, `wr_valid=0`, `upd_ready=1`.
  - All storage is zeroed, so `wr_addr`, `wr_index`, `wr_stat`, `wr_trend`, `wr_stat_en` and `wr_clear` are 0.
  - Reset beats flush, push and pop.
- Full: `upd_ready=0`. A request held with `upd_valid=1` waits and is never dropped or merged.
- Empty: `wr_valid=0` and `wr_ready` is ignored.
- Pointers wrap modulo `DEPTH`.
- `wr_*` are stable while `wr_valid && !wr_ready`.

## Configuration
- `PRED_UPD_MERGE_EN` defined: same-entry merging as described in Operation.
- Undefined:
  - Every accepted update occupies its own slot, computed from `upd_stat`/`upd_trend`.
  - Consecutive same-entry writes are emitted in order.
  - The merge comparators are not built.

## Test plan
- Reset, then one update (addr=5, taken=1, index={2'b10,2'b01,2'b11}, stat=0, trend=0) with `wr_ready=1`:
  - Next cycle `wr_valid=1`, `wr_stat={−1,+1,−1}`, `wr_trend={+1,−1,+1}`, `wr_stat_en=3'b111`, `wr_clear=0`.
  - `count` returns to 0 after the pop.
- Predictor 0 miss with stat=15 (S=5): `wr_stat_en[0]=0`, `wr_clear=1`. Trend=−3 on a miss stays −3.
- `wr_ready=0`, push 4 distinct addrs: `count=4`, `upd_ready=0`, `wr_*` hold entry 0. Then `wr_ready=1` drains in order 0..3.
- Two same-key updates on consecutive cycles, both misses, stat=0 (`PRED_UPD_MERGE_EN`): `count=1`, `wr_stat=+2`, `wr_trend=−2`. Without the macro: `count=2`, both entries `+1`/`−1`.
- `flush` asserted with `count=3` and a push in the same cycle: next cycle `count=0`, `wr_valid=0`.
- `rst` asserted with `count=2` mid-drain: next cycle all outputs are at their reset values.
